tau_uart_framer: RTL
====================

// Module: tau_uart_framer
// PURPOSE
//  Sits downstream of the YIN pitch detector. It frames each taumin result into a
//  4-byte packet for uart_transmit: SYNC, HI, LO, CHK.
//  It paces bytes against the UART busy flag and keeps a 1-deep latest-wins pending
//  slot, so pitch results arriving mid-frame are never lost silently.
//  Dropped results are counted for debug display.
// PARAMETERS
//  TAU_WIDTH  11     taumin width in bits; legal range 9..16
//  SYNC_BYTE  8'hA5  first byte of every frame
// PORTS
//  clk_in            in   1          system clock (100 MHz)
//  rst_in            in   1          reset, asynchronous, active-low
//  tau_in            in   TAU_WIDTH  pitch period from YIN
//  tau_valid_in      in   1          1-cycle strobe; tau_in valid this cycle
//  uart_busy_in      in   1          uart_transmit busy_out
//  byte_out          out  8          byte to transmit (uart data_byte_in)
//  byte_trigger_out  out  1          1-cycle strobe (uart trigger_in)
//  frame_active_out  out  1          high from frame start to last byte done
//  dropped_count_out out  16         results overwritten in pending slot, saturating
// BEHAVIOUR
//  Reset (rst_in=0, async): all outputs 0; state IDLE; pending slot empty; snapshot 0.
//  Frame bytes are computed from a snapshot S taken at frame start:
//   HI = zero-extended S[TAU_WIDTH-1:8]; LO = S[7:0]; CHK = SYNC_BYTE ^ HI ^ LO.
//  FSM states: IDLE, SEND, HOLD, WAIT.
//   IDLE: on tau_valid_in, S<=tau_in, idx<=0, frame_active<=1, go to SEND.
//         If tau_valid_in arrives while the pending slot is full (cannot happen in
//         IDLE), the same rules as below apply.
//   SEND: if !uart_busy_in, register byte_out<=byte[idx] and pulse byte_trigger_out
//         for exactly 1 cycle, then go to HOLD. Otherwise stay in SEND.
//   HOLD: exactly 1 cycle, uart_busy_in ignored (covers UART busy rise latency);
//         go to WAIT.
//   WAIT: when !uart_busy_in:
//         - idx<3: idx++ and go to SEND.
//         - idx==3 (frame done) and pending full: S<=pending, clear pending, idx<=0,
//           go to SEND. frame_active stays 1.
//         - idx==3 and pending empty: frame_active<=0, go to IDLE.
//  Latency: tau_valid_in at cycle t in IDLE with busy low -> byte_trigger_out with
//   byte_out=SYNC_BYTE at cycle t+2; byte_out is stable until the next trigger.
//  Pending slot (any state except IDLE-accept):
//   - tau_valid_in stores tau_in into the slot.
//   - If the slot was already full, it is overwritten and dropped_count_out++.
//  Simultaneous events:
//   - tau_valid_in in the same cycle WAIT consumes pending: the pending value is
//     consumed into S, the new value fills the now-empty slot, no drop counted.
//   - tau_valid_in in the same cycle WAIT finishes with pending empty: the new value
//     is stored in pending, the FSM goes to SEND with idx<=0 next via pending
//     (equivalent: no IDLE cycle, no drop).
//  dropped_count_out saturates at 16'hFFFF and never wraps.
//  Mid-frame reset: frame aborted immediately, no further triggers; a partially
//   sent frame is recovered by the host resyncing on SYNC_BYTE + CHK.
//  byte_trigger_out is never asserted while uart_busy_in=1 in the same cycle.
// TESTING
//  1. Model UART busy for 10 cycles starting the cycle after each trigger; tau=11'h5C3
//     -> exactly 4 triggers with bytes A5,05,C3,63; frame_active falls after 4th busy.
//  2. tau=0x7FF then a second tau=0x010 while byte 1 is in flight -> frame A5,07,FF,5D
//     then A5,00,10,B5 back-to-back; drop count 0.
//  3. Three results (0x100, 0x200, 0x300) during one frame -> next frame carries 0x300
//     (A5,03,00,A6); dropped_count_out=1.
//  4. Hold uart_busy_in=1 for 50 cycles before the first byte -> no trigger during busy;
//     SYNC sent on the first cycle busy is low.
//  5. Assert rst_in low asynchronously mid-byte 2 -> all outputs 0 within the same
//     cycle; after release a new tau sends a full fresh frame starting with A5.
//  6. Force 65537 drops -> dropped_count_out holds at 16'hFFFF.

Source files
------------

// File: rtl/tau_uart_framer.sv
// Frames each taumin result into a SYNC/HI/LO/CHK packet for uart_transmit, paced by the
// UART busy flag, with a latest-wins pending slot and a saturating drop counter.
module tau_uart_framer #(
    parameter int unsigned TAU_WIDTH = 11,  // legal range 9..16
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [TAU_WIDTH-1:0] tau_in,
    input  logic                 tau_valid_in,
    input  logic                 uart_busy_in,
    output logic [7:0]           byte_out,
    output logic                 byte_trigger_out,
    output logic                 frame_active_out,
    output logic [15:0]          dropped_count_out
);

    typedef enum logic [1:0] {StIdle, StSend, StHold, StWait} state_e;

    state_e               state_q;
    logic [TAU_WIDTH-1:0] snap_q;
    logic [TAU_WIDTH-1:0] pend_q;
    logic                 pend_valid_q;
    logic [1:0]           idx_q;
    logic [7:0]           byte_q;
    logic                 trig_q;
    logic                 active_q;
    logic [15:0]          drop_q;

    logic [15:0] snap_ext;
    logic [7:0]  hi_byte;
    logic [7:0]  lo_byte;
    logic [7:0]  cur_byte;

    // Zero-extension to 16 bits makes HI the upper taumin bits padded with zeros.
    assign snap_ext = 16'(snap_q);
    assign hi_byte  = snap_ext[15:8];
    assign lo_byte  = snap_ext[7:0];

    always_comb begin
        cur_byte = SYNC_BYTE;
        unique case (idx_q)
            2'd0: cur_byte = SYNC_BYTE;
            2'd1: cur_byte = hi_byte;
            2'd2: cur_byte = lo_byte;
            2'd3: cur_byte = SYNC_BYTE ^ hi_byte ^ lo_byte;
        endcase
    end

    logic frame_done;
    logic consume;
    logic restart_new;
    logic store_pend;
    logic drop_evt;

    always_comb begin
        frame_done  = (state_q == StWait) && !uart_busy_in && (idx_q == 2'd3);
        consume     = frame_done && pend_valid_q;
        // A result arriving exactly as the last byte completes starts the next frame directly.
        restart_new = frame_done && !pend_valid_q && tau_valid_in;
        store_pend  = tau_valid_in && (state_q != StIdle) && !restart_new;
        drop_evt    = store_pend && pend_valid_q && !consume;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            snap_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            idx_q        <= 2'd0;
            byte_q       <= 8'h00;
            trig_q       <= 1'b0;
            active_q     <= 1'b0;
            drop_q       <= 16'h0000;
        end else begin
            trig_q <= 1'b0;

            if (store_pend) begin
                pend_q       <= tau_in;
                pend_valid_q <= 1'b1;
            end else if (consume) begin
                pend_valid_q <= 1'b0;
            end

            if (drop_evt && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end

            unique case (state_q)
                StIdle: begin
                    if (tau_valid_in) begin
                        snap_q   <= tau_in;
                        idx_q    <= 2'd0;
                        active_q <= 1'b1;
                        state_q  <= StSend;
                    end
                end
                StSend: begin
                    if (!uart_busy_in) begin
                        byte_q  <= cur_byte;
                        trig_q  <= 1'b1;
                        state_q <= StHold;
                    end
                end
                // One blind cycle while the UART raises its busy flag.
                StHold: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (!uart_busy_in) begin
                        if (idx_q != 2'd3) begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= StSend;
                        end else if (consume) begin
                            snap_q  <= pend_q;
                            idx_q   <= 2'd0;
                            state_q <= StSend;
                        end else if (restart_new) begin
                            snap_q  <= tau_in;
                            idx_q   <= 2'd0;
                            state_q <= StSend;
                        end else begin
                            active_q <= 1'b0;
                            state_q  <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

    assign byte_out          = byte_q;
    assign byte_trigger_out  = trig_q;
    assign frame_active_out  = active_q;
    assign dropped_count_out = drop_q;

endmodule
